oc_chipmon_poller: RTL and testbench

Parametrised ChipMon supervisor that acts as a DRP master in front of a SYSMON-class monitor. It round-robin polls a configurable set of channel registers at a fixed interval and keeps latest, minimum and maximum values per channel. It also raises per-channel alarms from debounced, hysteretic threshold comparison. It sits between the ChipMon primitive's DRP port and the platform's thermal/voltage throttling logic, replacing the primitive's fixed ALM/OT outputs when more channels, custom thresholds or min/max history are needed.

---
 rtl/oclib_pkg.sv | 18 +
 rtl/oc_chipmon_poller_channel.sv | 71 +++++++
 rtl/oc_chipmon_poller.sv | 167 ++++++++++++++++
 tb/tb_oc_chipmon_poller.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oclib_pkg.sv
// Shared types and helpers for the oclib blocks.
package oclib_pkg;

  typedef enum logic [1:0] {
    PollIdle,
    PollIssue,
    PollWait,
    PollUpdate
  } chipmon_poll_state_e;

  localparam logic [15:0] CsrIdChipMonPoller = 16'h00c4;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/oc_chipmon_poller_channel.sv
// One polled channel: latest/min/max history plus debounced hysteretic alarm.
module oc_chipmon_poller_channel
  import oclib_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter logic [DataWidth-1:0] HighThreshold = '1,
  parameter logic [DataWidth-1:0] LowThreshold = '0,
  parameter int DebounceCount = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 update,
  input  logic                 clear,
  input  logic [DataWidth-1:0] value,
  output logic [DataWidth-1:0] latest,
  output logic [DataWidth-1:0] minimum,
  output logic [DataWidth-1:0] maximum,
  output logic                 alarm,
  output logic                 alarm_next
);

  localparam logic [7:0] DebLimit = 8'(DebounceCount);

  logic [7:0] set_count, clear_count, set_count_next, clear_count_next;

  // Counts saturate at the limit so a long run of samples cannot wrap.
  always_comb begin
    set_count_next   = set_count;
    clear_count_next = clear_count;
    alarm_next       = alarm;
    if (update) begin
      if (value > HighThreshold) begin
        clear_count_next = '0;
        set_count_next   = (set_count < DebLimit) ? set_count + 8'd1 : set_count;
        if (set_count_next == DebLimit) alarm_next = 1'b1;
      end else if (value < LowThreshold) begin
        set_count_next   = '0;
        clear_count_next = (clear_count < DebLimit) ? clear_count + 8'd1 : clear_count;
        if (clear_count_next == DebLimit) alarm_next = 1'b0;
      end else begin
        set_count_next   = '0;
        clear_count_next = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      latest      <= '0;
      minimum     <= '1;
      maximum     <= '0;
      set_count   <= '0;
      clear_count <= '0;
      alarm       <= 1'b0;
    end else begin
      set_count   <= set_count_next;
      clear_count <= clear_count_next;
      alarm       <= alarm_next;
      if (update) latest <= value;
      // A clear coinciding with an update wins; that sample never reaches min/max.
      if (clear) begin
        minimum <= '1;
        maximum <= '0;
      end else if (update) begin
        if (value < minimum) minimum <= value;
        if (value > maximum) maximum <= value;
      end
    end
  end

endmodule

// File: rtl/oc_chipmon_poller.sv
// DRP master that round-robin polls ChipMon channels and keeps history/alarms.
//   state      | meaning
//   PollIdle   | interval countdown, waiting for enable
//   PollIssue  | one-cycle DRP read strobe for channel ch
//   PollWait   | waiting for drpReady or timeout
//   PollUpdate | captured sample written into channel ch
module oc_chipmon_poller
  import oclib_pkg::*;
#(
  parameter int NumChannels = 4,
  parameter int DataWidth = 16,
  parameter int AddressWidth = 8,
  parameter logic [0:NumChannels-1][AddressWidth-1:0] ChannelAddress = {8'h00, 8'h01, 8'h02, 8'h06},
  parameter logic [0:NumChannels-1][DataWidth-1:0] HighThreshold = '1,
  parameter logic [0:NumChannels-1][DataWidth-1:0] LowThreshold = '0,
  parameter int DebounceCount = 4,
  parameter int PollInterval = 1000,
  parameter int TimeoutCycles = 64,
  parameter logic [NumChannels-1:0] ErrorMask = '0
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic                                 clearMinMax,
  output logic [AddressWidth-1:0]              drpAddress,
  output logic                                 drpEnable,
  output logic                                 drpWrite,
  output logic [DataWidth-1:0]                 drpWdata,
  input  logic [DataWidth-1:0]                 drpRdata,
  input  logic                                 drpReady,
  input  logic [width_for(NumChannels)-1:0]    selChannel,
  output logic [DataWidth-1:0]                 selValue,
  output logic [DataWidth-1:0]                 selMin,
  output logic [DataWidth-1:0]                 selMax,
  output logic [NumChannels-1:0]               alarm,
  output logic                                 warning,
  output logic                                 error,
  output logic                                 sampleValid,
  output logic                                 timeoutError
);

  localparam int ChWidth       = width_for(NumChannels);
  localparam int IntervalWidth = width_for(PollInterval);
  localparam int TimeoutWidth  = width_for(TimeoutCycles);
  localparam logic [ChWidth-1:0]       LastChannel    = ChWidth'(NumChannels - 1);
  localparam logic [IntervalWidth-1:0] IntervalReload = IntervalWidth'((PollInterval > 0) ? PollInterval - 1 : 0);
  localparam logic [TimeoutWidth-1:0]  TimeoutLast    = TimeoutWidth'(TimeoutCycles - 1);

  chipmon_poll_state_e state, state_next;
  logic [ChWidth-1:0]       ch, ch_next;
  logic [IntervalWidth-1:0] interval_count, interval_count_next;
  logic [TimeoutWidth-1:0]  timeout_count, timeout_count_next;
  logic [DataWidth-1:0]     sample, sample_next;
  logic                     timeout_error_next;
  logic                     advance;

  logic [NumChannels-1:0] update_vec, alarm_next_vec;
  logic [DataWidth-1:0]   latest_vec  [NumChannels];
  logic [DataWidth-1:0]   minimum_vec [NumChannels];
  logic [DataWidth-1:0]   maximum_vec [NumChannels];

  assign drpWrite = 1'b0;
  assign drpWdata = '0;

  always_comb begin
    state_next          = state;
    ch_next             = ch;
    interval_count_next = interval_count;
    timeout_count_next  = timeout_count;
    sample_next         = sample;
    timeout_error_next  = timeoutError;
    advance             = 1'b0;
    unique case (state)
      PollIdle: begin
        if (interval_count != '0) begin
          interval_count_next = interval_count - IntervalWidth'(1);
        end else if (enable) begin
          state_next = PollIssue;
          ch_next    = '0;
        end
      end
      PollIssue: begin
        timeout_count_next = '0;
        state_next         = PollWait;
      end
      PollWait: begin
        if (drpReady) begin
          sample_next = drpRdata;
          state_next  = PollUpdate;
        end else if (timeout_count == TimeoutLast) begin
          timeout_error_next = 1'b1;
          advance            = 1'b1;
        end else begin
          timeout_count_next = timeout_count + TimeoutWidth'(1);
        end
      end
      PollUpdate: advance = 1'b1;
      default: state_next = PollIdle;
    endcase
    // A timed-out channel moves on exactly like an updated one.
    if (advance) begin
      if (ch == LastChannel || !enable) begin
        state_next          = PollIdle;
        ch_next             = '0;
        interval_count_next = IntervalReload;
      end else begin
        state_next = PollIssue;
        ch_next    = ch + ChWidth'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= PollIdle;
      ch             <= '0;
      interval_count <= '0;
      timeout_count  <= '0;
      sample         <= '0;
      drpEnable      <= 1'b0;
      drpAddress     <= '0;
      sampleValid    <= 1'b0;
      timeoutError   <= 1'b0;
      warning        <= 1'b0;
      error          <= 1'b0;
    end else begin
      state          <= state_next;
      ch             <= ch_next;
      interval_count <= interval_count_next;
      timeout_count  <= timeout_count_next;
      sample         <= sample_next;
      drpEnable      <= (state_next == PollIssue);
      if (state_next == PollIssue) drpAddress <= ChannelAddress[ch_next];
      sampleValid    <= (state == PollUpdate);
      timeoutError   <= timeout_error_next;
      warning        <= |alarm_next_vec;
      error          <= |(alarm_next_vec & ErrorMask);
    end
  end

  for (genvar i = 0; i < NumChannels; i++) begin : g_channel
    assign update_vec[i] = (state == PollUpdate) && (ch == ChWidth'(i));

    oc_chipmon_poller_channel #(
      .DataWidth    (DataWidth),
      .HighThreshold(HighThreshold[i]),
      .LowThreshold (LowThreshold[i]),
      .DebounceCount(DebounceCount)
    ) u_channel (
      .clock     (clock),
      .reset     (reset),
      .update    (update_vec[i]),
      .clear     (clearMinMax),
      .value     (sample),
      .latest    (latest_vec[i]),
      .minimum   (minimum_vec[i]),
      .maximum   (maximum_vec[i]),
      .alarm     (alarm[i]),
      .alarm_next(alarm_next_vec[i])
    );
  end

  assign selValue = latest_vec[selChannel];
  assign selMin   = minimum_vec[selChannel];
  assign selMax   = maximum_vec[selChannel];

endmodule

// File: tb/tb_oc_chipmon_poller.sv
// Self-checking bench: DRP slave model, table sweeps, corner sequences, random sweeps.
module tb_oc_chipmon_poller;

  localparam int NCH = 4;
  localparam int DEB = 3;
  localparam int TIMEOUT = 8;
  localparam int IDLE_CYCLES = 20;
  localparam logic [3:0] ERR_MASK = 4'b0010;
  localparam int ADDR [NCH] = '{8'h00, 8'h01, 8'h02, 8'h06};
  localparam int HI   [NCH] = '{100, 200, 1000, 40000};
  localparam int LO   [NCH] = '{90, 50, 500, 30000};

  logic clock = 1'b0;
  logic reset, enable, clearMinMax, drpReady;
  logic [15:0] drpRdata;
  logic [1:0] selChannel;
  logic [7:0] drpAddress;
  logic drpEnable, drpWrite, warning, error, sampleValid, timeoutError;
  logic [15:0] drpWdata, selValue, selMin, selMax;
  logic [3:0] alarm;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  oc_chipmon_poller #(
    .NumChannels  (NCH),
    .HighThreshold({16'd100, 16'd200, 16'd1000, 16'd40000}),
    .LowThreshold ({16'd90, 16'd50, 16'd500, 16'd30000}),
    .DebounceCount(DEB),
    .PollInterval (20),
    .TimeoutCycles(TIMEOUT),
    .ErrorMask    (ERR_MASK)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .clearMinMax(clearMinMax),
    .drpAddress(drpAddress), .drpEnable(drpEnable), .drpWrite(drpWrite), .drpWdata(drpWdata),
    .drpRdata(drpRdata), .drpReady(drpReady), .selChannel(selChannel),
    .selValue(selValue), .selMin(selMin), .selMax(selMax), .alarm(alarm),
    .warning(warning), .error(error), .sampleValid(sampleValid), .timeoutError(timeoutError)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: per-channel history and debounce run lengths.
  int m_latest [NCH];
  int m_min [NCH];
  int m_max [NCH];
  int m_set [NCH];
  int m_clr [NCH];
  logic [3:0] m_alarm;
  logic m_timeout;

  // Per-sweep stimulus
  int sw_val [NCH];
  int sw_lat [NCH];
  bit sw_resp [NCH];
  int sw_clr = -1;
  int sw_drop = -1;
  int next_start = -1;
  int region [NCH];

  typedef struct {
    logic [15:0] v0;
    logic [15:0] v1;
    logic        exp_alarm0;
    logic        exp_warning;
    logic [15:0] exp_min1;
    logic [15:0] exp_max1;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_latest[c] = 0; m_min[c] = 16'hffff; m_max[c] = 0; m_set[c] = 0; m_clr[c] = 0;
    end
    m_alarm = '0;
    m_timeout = 1'b0;
  endtask

  task automatic model_update(input int c, input int v, input bit clr);
    m_latest[c] = v;
    if (!clr) begin
      if (v < m_min[c]) m_min[c] = v;
      if (v > m_max[c]) m_max[c] = v;
    end
    if (v > HI[c]) begin
      m_set[c]++; m_clr[c] = 0;
      if (m_set[c] >= DEB) m_alarm[c] = 1'b1;
    end else if (v < LO[c]) begin
      m_clr[c]++; m_set[c] = 0;
      if (m_clr[c] >= DEB) m_alarm[c] = 1'b0;
    end else begin
      m_set[c] = 0; m_clr[c] = 0;
    end
    if (clr) for (int k = 0; k < NCH; k++) begin m_min[k] = 16'hffff; m_max[k] = 0; end
  endtask

  task automatic check_model(input int c);
    selChannel = 2'(c);
    #1;
    chk($sformatf("ch%0d_value", c), selValue, m_latest[c]);
    chk($sformatf("ch%0d_min", c), selMin, m_min[c]);
    chk($sformatf("ch%0d_max", c), selMax, m_max[c]);
    chk("alarm", alarm, m_alarm);
    chk("warning", warning, |m_alarm);
    chk("error", error, |(m_alarm & ERR_MASK));
  endtask

  // Plays the DRP slave for one channel and checks the result two cycles after ready.
  task automatic do_channel(input int c, input int exp_issue, output int end_cyc);
    int n;
    int v;
    v = sw_val[c];
    n = 0;
    end_cyc = cyc;
    while (drpEnable !== 1'b1 && n < 400) begin @(negedge clock); n++; end
    if (drpEnable !== 1'b1) begin
      n_checks++;
      $display("FAIL issue_wait ch%0d: no drpEnable within 400 cycles", c);
      return;
    end
    chk($sformatf("ch%0d_issue_addr", c), drpAddress, ADDR[c]);
    if (exp_issue >= 0) chk($sformatf("ch%0d_issue_cycle", c), cyc, exp_issue);
    @(negedge clock);
    drpReady = 1'b0;
    chk("enable_pulse", drpEnable, 0);
    if (sw_drop == c) enable = 1'b0;
    if (sw_resp[c]) begin
      repeat (sw_lat[c]) @(negedge clock);
      chk("addr_hold", drpAddress, ADDR[c]);
      drpReady = 1'b1;
      drpRdata = 16'(v);
      @(negedge clock);
      drpReady = 1'b0;
      drpRdata = 16'($urandom);
      chk("no_early_valid", sampleValid, 0);
      if (sw_clr == c) clearMinMax = 1'b1;
      end_cyc = cyc;
      @(negedge clock);
      clearMinMax = 1'b0;
      model_update(c, v, sw_clr == c);
      chk("sample_valid", sampleValid, 1);
      check_model(c);
    end else begin
      repeat (TIMEOUT - 1) @(negedge clock);
      chk("timeout_pending", timeoutError, m_timeout);
      end_cyc = cyc;
      @(negedge clock);
      m_timeout = 1'b1;
      chk("timeout_error", timeoutError, 1);
      chk("timeout_no_valid", sampleValid, 0);
      check_model(c);
      drpReady = 1'b1;
      drpRdata = 16'hbeef;
    end
  endtask

  task automatic do_sweep(input int exp_first);
    int e;
    int endc;
    bit stop;
    e = exp_first;
    stop = 1'b0;
    for (int c = 0; c < NCH && !stop; c++) begin
      do_channel(c, e, endc);
      if (sw_drop == c) stop = 1'b1;
      e = (c == NCH - 1) ? endc + 1 + IDLE_CYCLES : endc + 1;
    end
    next_start = stop ? -1 : e;
  endtask

  function automatic int pick(input int c, input int r);
    case (r)
      0:       return int'($urandom_range(LO[c] - 1, 0));
      1:       return int'($urandom_range(HI[c], LO[c]));
      default: return int'($urandom_range(HI[c] + 100, HI[c] + 1));
    endcase
  endfunction

  task automatic random_sweeps(input int count);
    for (int s = 0; s < count; s++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(2, 0) == 0) region[c] = int'($urandom_range(2, 0));
        sw_val[c] = pick(c, region[c]);
        sw_lat[c] = int'($urandom_range(3, 0));
        sw_resp[c] = ($urandom_range(15, 0) != 0);
      end
      sw_clr = ($urandom_range(5, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
      do_sweep(next_start);
    end
    sw_clr = -1;
    for (int c = 0; c < NCH; c++) sw_resp[c] = 1'b1;
  endtask

  initial begin
    int bad;
    int n;
    tbl[0] = '{16'd101, 16'd50,  1'b0, 1'b0, 16'd50, 16'd50};
    tbl[1] = '{16'd101, 16'd200, 1'b0, 1'b0, 16'd50, 16'd200};
    tbl[2] = '{16'd101, 16'd10,  1'b1, 1'b1, 16'd10, 16'd200};
    tbl[3] = '{16'd95,  16'd30,  1'b1, 1'b1, 16'd10, 16'd200};
    tbl[4] = '{16'd89,  16'd250, 1'b1, 1'b1, 16'd10, 16'd250};
    tbl[5] = '{16'd89,  16'd10,  1'b1, 1'b1, 16'd10, 16'd250};
    tbl[6] = '{16'd89,  16'd20,  1'b0, 1'b0, 16'd10, 16'd250};

    reset = 1'b0; enable = 1'b0; clearMinMax = 1'b0; drpReady = 1'b0;
    drpRdata = '0; selChannel = '0;
    for (int c = 0; c < NCH; c++) begin sw_lat[c] = 1; sw_resp[c] = 1'b1; region[c] = 1; end
    model_reset();

    repeat (3) @(negedge clock);
    chk("rst_drp_enable", drpEnable, 0);
    chk("rst_drp_address", drpAddress, 0);
    chk("rst_sample_valid", sampleValid, 0);
    chk("rst_timeout", timeoutError, 0);
    chk("drp_write", drpWrite, 0);
    chk("drp_wdata", drpWdata, 0);
    for (int c = 0; c < NCH; c++) check_model(c);

    reset = 1'b1;
    enable = 1'b1;
    next_start = cyc + 1;

    // Debounce on ch0 and min/max on ch1, 1-cycle DRP latency, fixed sweep spacing.
    for (int r = 0; r < 7; r++) begin
      sw_val[0] = tbl[r].v0;
      sw_val[1] = tbl[r].v1;
      sw_val[2] = 700;
      sw_val[3] = 35000;
      do_sweep(next_start);
      selChannel = 2'd1;
      #1;
      chk($sformatf("tbl%0d_alarm0", r), alarm[0], tbl[r].exp_alarm0);
      chk($sformatf("tbl%0d_warning", r), warning, tbl[r].exp_warning);
      chk($sformatf("tbl%0d_value1", r), selValue, tbl[r].v1);
      chk($sformatf("tbl%0d_min1", r), selMin, tbl[r].exp_min1);
      chk($sformatf("tbl%0d_max1", r), selMax, tbl[r].exp_max1);
    end

    // clearMinMax in the Update cycle of a 70 sample on ch1.
    sw_val[0] = 95; sw_val[1] = 70;
    sw_clr = 1;
    do_sweep(next_start);
    sw_clr = -1;
    selChannel = 2'd1;
    #1;
    chk("clr_latest1", selValue, 70);
    chk("clr_min1", selMin, 16'hffff);
    chk("clr_max1", selMax, 0);

    // ch2 never answers; ch3 must still be polled.
    sw_resp[2] = 1'b0;
    sw_val[1] = 120; sw_val[2] = 800; sw_val[3] = 31000;
    do_sweep(next_start);
    sw_resp[2] = 1'b1;
    chk("timeout_sticky", timeoutError, 1);

    // Enable dropped during ch1 Wait: ch1 completes, then the poller parks.
    sw_drop = 1;
    sw_val[0] = 92; sw_val[1] = 60;
    do_sweep(next_start);
    sw_drop = -1;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (drpEnable !== 1'b0) bad++;
    end
    chk("idle_after_drop", bad, 0);
    enable = 1'b1;
    next_start = cyc + 1;
    do_sweep(next_start);

    random_sweeps(24);

    // Reset during Wait, then a stale ready must be ignored.
    n = 0;
    while (drpEnable !== 1'b1 && n < 400) begin @(negedge clock); n++; end
    if (drpEnable !== 1'b1) begin
      n_checks++;
      $display("FAIL reset_seq: no drpEnable within 400 cycles");
    end
    @(negedge clock);
    reset = 1'b0;
    enable = 1'b0;
    @(negedge clock);
    model_reset();
    chk("mid_rst_drp_enable", drpEnable, 0);
    chk("mid_rst_drp_address", drpAddress, 0);
    chk("mid_rst_sample_valid", sampleValid, 0);
    chk("mid_rst_timeout", timeoutError, 0);
    for (int c = 0; c < NCH; c++) check_model(c);
    reset = 1'b1;
    drpReady = 1'b1;
    drpRdata = 16'd1234;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (sampleValid !== 1'b0 || drpEnable !== 1'b0) bad++;
    end
    drpReady = 1'b0;
    chk("stale_ready_ignored", bad, 0);
    for (int c = 0; c < NCH; c++) check_model(c);

    enable = 1'b1;
    next_start = cyc + 1;
    random_sweeps(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
